// File: rtl/a_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a_fifo_pkg
// Purpose  : Shared defaults and the sample-word type for the audio-sample
//            FIFO of the spectrum-analyser datapath.
// Contents : A_FIFO_DATA_WIDTH    - default stored word width (24)
//            A_FIFO_ADDRESS_WIDTH - default log2 of FIFO depth (4 -> 16)
//            a_fifo_word_t        - one sample word at the default width
// Revision : 1.0 - initial release
// ============================================================================
package a_fifo_pkg;

  localparam int A_FIFO_DATA_WIDTH    = 24;
  localparam int A_FIFO_ADDRESS_WIDTH = 4;

  typedef logic [A_FIFO_DATA_WIDTH-1:0] a_fifo_word_t;

endpackage
`default_nettype wire

// File: rtl/a_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : a_fifo_if
// Purpose  : Producer/consumer handshake bundle of the audio-sample FIFO.
// Signals  : Data_in    - write data             (master -> FIFO)
//            WriteEn_in - write request          (master -> FIFO)
//            ReadEn_in  - read request           (master -> FIFO)
//            Full_out   - FIFO holds depth words (FIFO -> master)
//            Empty_out  - FIFO holds zero words  (FIFO -> master)
//            Data_out   - registered read data   (FIFO -> master)
// Modports : master - the producer/consumer side
//            slave  - the FIFO itself
// Revision : 1.0 - initial release
// ============================================================================
interface a_fifo_if
  import a_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = A_FIFO_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] Data_in;
  logic                  WriteEn_in;
  logic                  Full_out;
  logic                  ReadEn_in;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  Empty_out;

  modport master (
    output Data_in,
    output WriteEn_in,
    output ReadEn_in,
    input  Full_out,
    input  Empty_out,
    input  Data_out
  );

  modport slave (
    input  Data_in,
    input  WriteEn_in,
    input  ReadEn_in,
    output Full_out,
    output Empty_out,
    output Data_out
  );

endinterface
`default_nettype wire

// File: rtl/a_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : a_fifo_mem
// Purpose  : Simple dual-port storage array for the audio-sample FIFO.
//            The array itself has no reset so it maps onto block RAM; only
//            the read-data output register is cleared.
// Ports    : clk       - clock for both ports
//            rst       - asynchronous active-high clear of o_rd_data
//            i_wr_en   - write strobe
//            i_wr_addr - write address
//            i_wr_data - write data
//            i_rd_en   - read strobe, loads o_rd_data
//            i_rd_addr - read address
//            o_rd_data - registered read data, held when i_rd_en is low
// Revision : 1.0 - initial release
// ============================================================================
module a_fifo_mem
  import a_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = A_FIFO_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = A_FIFO_ADDRESS_WIDTH
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_wr_en,
  input  wire logic [ADDRESS_WIDTH-1:0] i_wr_addr,
  input  wire logic [DATA_WIDTH-1:0]    i_wr_data,
  input  wire logic                     i_rd_en,
  input  wire logic [ADDRESS_WIDTH-1:0] i_rd_addr,
  output logic      [DATA_WIDTH-1:0]    o_rd_data
);

  localparam int c_depth = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
    end else if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/a_fifo.sv
`default_nettype none
// ============================================================================
// Module   : a_fifo
// Purpose  : Single-clock FIFO decoupling the audio-sample producer from the
//            spectrum-analyser consumer. Holds the read/write pointers, the
//            full/empty decode and the acceptance logic around a_fifo_mem.
// Ports    : Clk      - single clock, all state changes on the rising edge
//            Clear_in - asynchronous active-high clear; empties the FIFO and
//                       zeroes Data_out (stored words are left in place)
//            bus      - a_fifo_if slave: Data_in, WriteEn_in, ReadEn_in,
//                       Full_out, Empty_out, Data_out
// Revision : 1.0 - initial release
// ============================================================================
module a_fifo
  import a_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = A_FIFO_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = A_FIFO_ADDRESS_WIDTH
) (
  input wire logic Clk,
  input wire logic Clear_in,
  a_fifo_if.slave  bus
);

  localparam logic [ADDRESS_WIDTH:0] c_ptr_one = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [ADDRESS_WIDTH:0] r_wptr;
  logic [ADDRESS_WIDTH:0] r_rptr;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come from the registered pointers alone, never from the enables.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDRESS_WIDTH-1:0] == r_rptr[ADDRESS_WIDTH-1:0]) &&
                   (r_wptr[ADDRESS_WIDTH] != r_rptr[ADDRESS_WIDTH]);

  // The memory write port has no clear of its own, so a request coinciding
  // with Clear_in must be blocked here to keep the array untouched.
  assign w_wr_acc = bus.WriteEn_in && !w_full  && !Clear_in;
  assign w_rd_acc = bus.ReadEn_in  && !w_empty && !Clear_in;

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
    end
  end

  a_fifo_mem #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_mem (
    .clk       (Clk),
    .rst       (Clear_in),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr[ADDRESS_WIDTH-1:0]),
    .i_wr_data (bus.Data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr[ADDRESS_WIDTH-1:0]),
    .o_rd_data (bus.Data_out)
  );

  assign bus.Full_out  = w_full;
  assign bus.Empty_out = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_a_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_fifo
// Purpose  : Self-checking bench for a_fifo: a table of directed vectors
//            (reset, fill, overflow, drain, underflow, simultaneous access at
//            empty and at full) followed by hand-written streaming and
//            asynchronous-clear sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_fifo;
  import a_fifo_pkg::*;

  typedef struct {
    logic         clr;
    logic         we;
    logic         re;
    a_fifo_word_t din;
    logic         exp_empty;
    logic         exp_full;
    a_fifo_word_t exp_dout;
  } vec_t;

  logic CLK_48_sig;
  logic clear_sig;

  int n_checks;
  int n_pass;

  vec_t vecs[$];

  a_fifo_if #(.DATA_WIDTH(A_FIFO_DATA_WIDTH)) bus ();

  a_fifo #(
    .DATA_WIDTH    (A_FIFO_DATA_WIDTH),
    .ADDRESS_WIDTH (A_FIFO_ADDRESS_WIDTH)
  ) dut (
    .Clk      (CLK_48_sig),
    .Clear_in (clear_sig),
    .bus      (bus)
  );

  initial CLK_48_sig = 1'b0;
  always #5 CLK_48_sig = ~CLK_48_sig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic clr, input logic we, input logic re,
                         input a_fifo_word_t din, input logic ee,
                         input logic ef, input a_fifo_word_t ed);
    vec_t v;
    v.clr = clr; v.we = we; v.re = re; v.din = din;
    v.exp_empty = ee; v.exp_full = ef; v.exp_dout = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic we, input logic re, input a_fifo_word_t din);
    clear_sig      = clr;
    bus.WriteEn_in = we;
    bus.ReadEn_in  = re;
    bus.Data_in    = din;
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge CLK_48_sig);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic ee, input logic ef, input a_fifo_word_t ed);
    check({tag, " empty"}, {31'd0, bus.Empty_out}, {31'd0, ee});
    check({tag, " full"},  {31'd0, bus.Full_out},  {31'd0, ef});
    check({tag, " dout"},  {8'd0, bus.Data_out},   {8'd0, ed});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // ---------------- vector table ----------------
    // Reset held 5 cycles with reads and writes requested: nothing changes.
    for (int i = 0; i < 5; i++) add_vec(1, 1, 1, 24'h00_0099, 1, 0, 24'h0);
    // Fill 1..16; Full rises after the 16th write.
    for (int i = 0; i < 16; i++) add_vec(0, 1, 0, a_fifo_word_t'(i + 1), 0, (i == 15), 24'h0);
    // 17th write dropped.
    add_vec(0, 1, 0, 24'd17, 0, 1, 24'h0);
    // Drain 16 in order.
    for (int i = 0; i < 16; i++) add_vec(0, 0, 1, 24'h0, (i == 15), 0, a_fifo_word_t'(i + 1));
    // Read while empty: Data_out holds 16.
    add_vec(0, 0, 1, 24'h0, 1, 0, 24'd16);
    // Read+write while empty: only the write lands, Data_out unchanged.
    add_vec(0, 1, 1, 24'h0000AA, 0, 0, 24'd16);
    add_vec(0, 0, 1, 24'h0, 1, 0, 24'h0000AA);
    // Fill again (pointers cross the wrap), then read+write while full.
    for (int i = 0; i < 16; i++) add_vec(0, 1, 0, a_fifo_word_t'(24'h100 + i), 0, (i == 15), 24'h0000AA);
    add_vec(0, 1, 1, 24'h00DEAD, 0, 0, 24'h000100);
    // The remaining 15 words come out; 0xDEAD was lost.
    for (int i = 0; i < 15; i++) add_vec(0, 0, 1, 24'h0, (i == 14), 0, a_fifo_word_t'(24'h101 + i));
    add_vec(0, 0, 1, 24'h0, 1, 0, 24'h00010F);

    // ---------------- apply ----------------
    drive(1, 0, 0, 24'h0);
    #1;
    check_flags("reset-immediate", 1, 0, 24'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].re, vecs[i].din);
      step();
      check_flags($sformatf("vec[%0d]", i), vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_dout);
    end

    // ---------------- streaming ----------------
    drive(1, 1, 1, 24'h0);
    step();
    check_flags("stream-clear", 1, 0, 24'h0);
    for (int k = 0; k < 100; k++) begin
      drive(0, 1, 1, a_fifo_word_t'(k));
      step();
      check("stream full", {31'd0, bus.Full_out}, 32'd0);
      if (k == 0) begin
        check("stream first empty", {31'd0, bus.Empty_out}, 32'd0);
        check("stream first dout", {8'd0, bus.Data_out}, 32'd0);
      end else begin
        check($sformatf("stream dout[%0d]", k), {8'd0, bus.Data_out}, 32'(k - 1));
      end
    end

    // ---------------- asynchronous clear with 8 stored ----------------
    drive(1, 0, 0, 24'h0);
    step();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, a_fifo_word_t'(24'h300 + i));
      step();
    end
    drive(0, 0, 1, 24'h0);
    step();
    check_flags("pre-clear", 0, 0, 24'h000300);
    drive(0, 0, 0, 24'h0);
    #3;
    clear_sig = 1'b1;
    #1;
    check_flags("async-clear", 1, 0, 24'h0);
    step();
    drive(0, 1, 0, 24'h0005A5);
    step();
    check("post-clear write empty", {31'd0, bus.Empty_out}, 32'd0);
    drive(0, 0, 1, 24'h0);
    step();
    check_flags("post-clear read", 1, 0, 24'h0005A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
